// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and default bus widths.
package dmem_arb_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  typedef enum logic [1:0] {
    CPU   = 2'd0,
    HOST  = 2'd1,
    YIELD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_burst_cnt.sv
// Host burst counter: cleared on HOST entry, counts acks, flags the ack that reaches MAX_BURST.
module arb_burst_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 8,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(MAX_BURST))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Terminal count seen on the incrementing cycle, so the FSM can leave HOST on that same ack.
  assign o_tc = i_inc && (r_cnt == CW'(MAX_BURST - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU data port and a host/debug port.
// Optional statistics counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW,
  parameter int MAX_BURST = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_wmem,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_run,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]   stall_cycles,
  output logic [31:0]   host_writes,
`endif
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e    r_state;
  arb_state_e    w_state_next;
  logic          w_host_cycle;
  logic          w_clr;
  logic          w_tc;
  logic [DW-1:0] r_host_rdata;

  // The host owns the port only while it is actually requesting in HOST; a HOST cycle with the
  // request already dropped is handed back to the CPU, so leaving a burst costs the CPU nothing.
  assign w_host_cycle = (r_state == HOST) && host_req;
  assign w_clr        = (r_state != HOST) && host_req;

  assign cpu_run    = !w_host_cycle;
  assign host_ack   = w_host_cycle;
  assign mem_addr   = w_host_cycle ? host_addr  : cpu_addr;
  assign mem_wdata  = w_host_cycle ? host_wdata : cpu_wdata;
  assign mem_we     = w_host_cycle ? host_we    : cpu_wmem;
  assign cpu_rdata  = w_host_cycle ? '0         : mem_rdata;
  assign host_rdata = r_host_rdata;

  arb_burst_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_cnt (
    .clock  (clock),
    .resetn (resetn),
    .i_clr  (w_clr),
    .i_inc  (w_host_cycle),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_state_next = host_req ? HOST : CPU;
    if (r_state == HOST) begin
      if (w_tc) begin
        w_state_next = YIELD;
      end else if (!host_req) begin
        w_state_next = CPU;
      end else begin
        w_state_next = HOST;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= CPU;
      r_host_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_host_cycle && !host_we) begin
        r_host_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_host_writes;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall_cycles <= '0;
      r_host_writes  <= '0;
    end else begin
      if (w_host_cycle && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_host_cycle && host_we && (r_host_writes != 32'hFFFF_FFFF)) begin
        r_host_writes <= r_host_writes + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign host_writes  = r_host_writes;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a
// cycle-level ownership model and a reference copy of the data memory.
module tb_dmem_arbiter;

  localparam int MB = 8;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_wmem, cpu_run;
  logic        host_req, host_we, host_ack;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cycles, host_writes;
`endif

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MB)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wmem   (cpu_wmem),
    .cpu_rdata  (cpu_rdata),
    .cpu_run    (cpu_run),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
`ifdef DMEM_ARB_STATS_EN
    .stall_cycles (stall_cycles),
    .host_writes  (host_writes),
`endif
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Physical memory seen by the DUT, and the bench's own expectation of its contents.
  logic [31:0] dmem    [0:255];
  logic [31:0] ref_mem [0:255];
  assign mem_rdata = dmem[mem_addr[9:2]];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: whether the host currently holds the grant, and how many acks it has had in this grant.
  bit          m_in_host;
  int          m_streak;
  logic [31:0] m_host_rdata;
  int          m_stall, m_hw;

  logic        e_run, e_ack, e_we;
  logic [31:0] e_addr, e_wd, e_crd;
  logic        g_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_in_host    = 1'b0;
    m_streak     = 0;
    m_host_rdata = '0;
    m_stall      = 0;
    m_hw         = 0;
  endtask

  task automatic compute_exp();
    e_ack  = m_in_host && host_req && resetn;
    e_run  = !e_ack;
    e_we   = e_ack ? host_we    : cpu_wmem;
    e_addr = e_ack ? host_addr  : cpu_addr;
    e_wd   = e_ack ? host_wdata : cpu_wdata;
    e_crd  = e_ack ? 32'd0      : ref_mem[cpu_addr[9:2]];
  endtask

  task automatic check_phase();
    @(negedge clock);
    compute_exp();
    g_ack = host_ack;
    chk("cpu_run",    {31'd0, cpu_run},  {31'd0, e_run});
    chk("host_ack",   {31'd0, host_ack}, {31'd0, e_ack});
    chk("mem_we",     {31'd0, mem_we},   {31'd0, e_we});
    chk("mem_addr",   mem_addr,   e_addr);
    chk("mem_wdata",  mem_wdata,  e_wd);
    chk("cpu_rdata",  cpu_rdata,  e_crd);
    chk("host_rdata", host_rdata, m_host_rdata);
`ifdef DMEM_ARB_STATS_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("host_writes",  host_writes,  m_hw);
`endif
    if (host_ack)
      $display("[TB] t=%0t host %s addr=0x%08h wdata=0x%08h", $time,
               host_we ? "WR" : "RD", host_addr, host_wdata);
  endtask

  task automatic commit_phase();
    logic        cap_we;
    logic [31:0] cap_a, cap_d;
    cap_we = mem_we;
    cap_a  = mem_addr;
    cap_d  = mem_wdata;
    compute_exp();
    @(posedge clock);
    #1;
    if (cap_we) dmem[cap_a[9:2]] = cap_d;
    if (e_ack && !host_we) m_host_rdata = ref_mem[host_addr[9:2]];
    if (e_we) ref_mem[e_addr[9:2]] = e_wd;
    if (e_ack) m_stall++;
    if (e_ack && host_we) m_hw++;
    if (!m_in_host) begin
      m_in_host = host_req;
      m_streak  = 0;
    end else if (e_ack) begin
      m_streak++;
      if (m_streak == MB) m_in_host = 1'b0;
    end else begin
      m_in_host = 1'b0;
    end
    if (!resetn) model_reset();
  endtask

  task automatic cycle();
    check_phase();
    commit_phase();
  endtask

  initial begin
    logic [22:0] ack_bits;
    logic [31:0] saved;
    int          acks, stalls;

    for (int i = 0; i < 256; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    model_reset();
    resetn     = 1'b0;
    cpu_addr   = 32'h10;
    cpu_wdata  = 32'h1234_5678;
    cpu_wmem   = 1'b1;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = 32'h0;
    host_wdata = 32'h0;

    // Reset state: CPU owns the port and its store strobe passes straight through.
    check_phase();
    chk("rst_run",  {31'd0, cpu_run},  32'd1);
    chk("rst_we",   {31'd0, mem_we},   32'd1);
    chk("rst_addr", mem_addr,          32'h10);
    chk("rst_ack",  {31'd0, host_ack}, 32'd0);
    chk("rst_hrd",  host_rdata,        32'd0);
    commit_phase();
    resetn   = 1'b1;
    cpu_wmem = 1'b0;
    cycle();

    // Host write 0xDEADBEEF to 0x40 from idle.
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h40; host_wdata = 32'hDEAD_BEEF;
    cpu_addr = 32'h80;
    check_phase();
    chk("wr_lat_ack", {31'd0, host_ack}, 32'd0);
    commit_phase();
    check_phase();
    chk("wr_ack",  {31'd0, host_ack}, 32'd1);
    chk("wr_we",   {31'd0, mem_we},   32'd1);
    chk("wr_data", mem_wdata,         32'hDEAD_BEEF);
    chk("wr_run",  {31'd0, cpu_run},  32'd0);
    commit_phase();
    host_req = 1'b0;
    cpu_addr = 32'h40;
    check_phase();
    chk("wr_run_after", {31'd0, cpu_run}, 32'd1);
    chk("cpu_rd40",     cpu_rdata,        32'hDEAD_BEEF);
    commit_phase();

    // CPU store strobe high during a host write must not reach the CPU's address.
    saved = ref_mem[32'h48 >> 2];
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h44; host_wdata = 32'h5555_AAAA;
    cpu_addr = 32'h48; cpu_wdata = 32'hBAD0_BAD0; cpu_wmem = 1'b0;
    cycle();
    cpu_wmem = 1'b1;
    check_phase();
    chk("hold_ack",  {31'd0, host_ack}, 32'd1);
    chk("hold_addr", mem_addr,          32'h44);
    commit_phase();
    host_req = 1'b0; cpu_wmem = 1'b0;
    check_phase();
    chk("cpu_addr_intact", cpu_rdata, saved);
    commit_phase();

    // 20 back-to-back reads with MAX_BURST = 8, from a fresh reset.
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h100;
    acks = 0; stalls = 0; ack_bits = '0;
    for (int c = 0; c < 23; c++) begin
      check_phase();
      ack_bits = {ack_bits[21:0], host_ack};
      if (!cpu_run) stalls++;
      commit_phase();
      if (g_ack) begin
        acks++;
        host_addr = host_addr + 32'd4;
        if (acks == 20) host_req = 1'b0;
      end
    end
    chk("burst_acks",    acks,     32'd20);
    chk("burst_pattern", {9'd0, ack_bits}, {9'd0, 23'b0_11111111_0_11111111_0_1111});
    chk("burst_stalls",  stalls,   32'd20);
    check_phase();
    chk("burst_done_run", {31'd0, cpu_run}, 32'd1);
`ifdef DMEM_ARB_STATS_EN
    chk("stats_stall", stall_cycles, 32'd20);
    chk("stats_hw",    host_writes,  32'd0);
`endif
    commit_phase();

    // Reset asserted during the 3rd access of a read burst.
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40;
    cycle();
    cycle();
    cycle();
    check_phase();
    chk("mid_ack_before", {31'd0, host_ack}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_ack", {31'd0, host_ack}, 32'd0);
    chk("mid_rst_run", {31'd0, cpu_run},  32'd1);
    chk("mid_rst_hrd", host_rdata,        32'd0);
    model_reset();
    host_req = 1'b0;
    commit_phase();
    resetn = 1'b1;
    host_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      check_phase();
      commit_phase();
      if (g_ack) acks++;
    end
    chk("rereq_acks", acks, MB);
    host_req = 1'b0;
    cycle();

    // Random traffic; host holds its request and payload until acknowledged.
    for (int c = 0; c < 600; c++) begin
      cycle();
      cpu_addr  = {22'd0, 8'($urandom), 2'b00};
      cpu_wdata = $urandom;
      cpu_wmem  = 1'($urandom_range(0, 1));
      if (!host_req || g_ack) begin
        host_req   = ($urandom_range(0, 3) != 0);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = {22'd0, 8'($urandom), 2'b00};
        host_wdata = $urandom;
      end
    end
    host_req = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
